// File: rtl/scan_pkg.sv
// Shared definitions for the 74138 digit-scan controller.
package scan_pkg;

    // Scan FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Decoder enable triple, ordered {g1, g2a_n, g2b_n}.
    localparam logic [2:0] DEC_OFF = 3'b011;
    localparam logic [2:0] DEC_ON  = 3'b100;

    // Next digit index; an index already at or above last wraps to 0.
    function automatic logic [2:0] next_index(input logic [2:0] idx,
                                              input logic [2:0] last);
        return (idx >= last) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/cyc_counter.sv
// Elapsed-cycle counter: cleared to 0 on clr, otherwise counts up.
// tc flags the cycle whose count equals the terminal value.
module cyc_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count;

    // Count cycles spent in the current state; clear on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tc = (count == term);

endmodule

// File: rtl/scan_ctrl_74138.sv
// Multiplexed display scanner driving a 74138 3-to-8 decoder.
// Each digit gets BLANK_CYC cycles with the decoder disabled, then
// SHOW_CYC cycles enabled; the index only moves while disabled.
module scan_ctrl_74138
    import scan_pkg::*;
#(
    parameter int unsigned SHOW_CYC  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] last_digit,
    output logic [0:2] x,
    output logic       g1,
    output logic       g2a_n,
    output logic       g2b_n,
    output logic       digit_tick,
    output logic [2:0] digit_idx
);

    localparam int unsigned MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] SHOW_TERM  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] BLANK_TERM = CW'(BLANK_CYC - 1);

    scan_state_t   state;
    logic [2:0]    idx;
    logic          armed;
    logic          tc;
    logic          cnt_clr;
    logic [CW-1:0] cnt_term;

    // Terminal count and clear follow the state the FSM is leaving.
    always_comb begin
        cnt_term = (state == ST_SHOW) ? SHOW_TERM : BLANK_TERM;
        cnt_clr  = 1'b1;
        if (en) begin
            case (state)
                ST_BLANK, ST_SHOW: cnt_clr = tc;
                default:           cnt_clr = 1'b1;
            endcase
        end
    end

    cyc_counter #(.W(CW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .term (cnt_term),
        .tc   (tc)
    );

    // Scan FSM with registered decoder enables, index and tick.
    // 'armed' makes the first edge after reset only sample IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= ST_IDLE;
            idx                 <= 3'd0;
            armed               <= 1'b0;
            {g1, g2a_n, g2b_n}  <= DEC_OFF;
            digit_tick          <= 1'b0;
        end else begin
            armed      <= 1'b1;
            digit_tick <= 1'b0;
            if (!en) begin
                state              <= ST_IDLE;
                idx                <= 3'd0;
                {g1, g2a_n, g2b_n} <= DEC_OFF;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (armed) begin
                            state <= ST_BLANK;
                            idx   <= 3'd0;
                        end
                    end
                    ST_BLANK: begin
                        if (tc) begin
                            state              <= ST_SHOW;
                            {g1, g2a_n, g2b_n} <= DEC_ON;
                            digit_tick         <= 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (tc) begin
                            state              <= ST_BLANK;
                            idx                <= next_index(idx, last_digit);
                            {g1, g2a_n, g2b_n} <= DEC_OFF;
                        end
                    end
                    default: begin
                        state              <= ST_IDLE;
                        idx                <= 3'd0;
                        {g1, g2a_n, g2b_n} <= DEC_OFF;
                    end
                endcase
            end
        end
    end

    // x[0] is the MSB of the index.
    assign x         = idx;
    assign digit_idx = idx;

endmodule
